// File: rtl/reaction_game_ctrl_if.sv
// Player-side signal bundle of the reaction game controller: the
// tick/key/arm inputs and the digit, LED and debug outputs.
interface reaction_game_ctrl_if;
    logic       start;
    logic       btn_n;
    logic       ms_tick;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] digit_en;
    logic       go_led;
    logic [2:0] state;

    modport master (
        output start, btn_n, ms_tick,
        input  digit0, digit1, digit2, digit3, digit_en, go_led, state
    );

    modport slave (
        input  start, btn_n, ms_tick,
        output digit0, digit1, digit2, digit3, digit_en, go_led, state
    );
endinterface

// File: rtl/reaction_game_ctrl.sv
// Reaction-time game controller: countdown, random hold-off, reaction timing
// as 4-digit BCD (s.cs + ms) and disqualification on an early key press.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a rising edge on the arm switch, display blank
// CNTDN | counting down whole seconds, value shown on digit0
// WAIT  | random hold-off, display blank; any press disqualifies
// GO    | go_led on, live BCD reaction time counting in ms
// DONE  | reaction time frozen on the display
// DISQ  | "dis" shown on digit3..1 after a press before GO
module reaction_game_ctrl #(
    parameter int unsigned COUNT_SEC   = 3,
    parameter int unsigned WAIT_MIN_MS = 1000,
    parameter logic [11:0] LFSR_SEED   = 12'hACE,
    parameter logic [3:0]  GLYPH_D     = 4'd13,
    parameter logic [3:0]  GLYPH_I     = 4'd1,
    parameter logic [3:0]  GLYPH_S     = 4'd5
) (
    input logic                 clk,
    input logic                 reset_n,
    reaction_game_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CNTDN = 3'd1,
        ST_WAIT  = 3'd2,
        ST_GO    = 3'd3,
        ST_DONE  = 3'd4,
        ST_DISQ  = 3'd5
    } state_t;

    state_t      state_q, state_nxt;
    logic [3:0]  cd_q, cd_nxt;
    logic [9:0]  ms_q, ms_nxt;
    logic [12:0] wait_q, wait_nxt;
    logic [15:0] bcd_q, bcd_nxt;
    logic [11:0] lfsr_q;

    logic [1:0]  start_sync_q;
    logic        start_prev_q;
    logic [1:0]  btn_sync_q;
    logic        btn_prev_q;
    logic        start_s;
    logic        start_rise;
    logic        press;

    logic [3:0]  d0_q, d1_q, d2_q, d3_q, en_q;
    logic [3:0]  d0_nxt, d1_nxt, d2_nxt, d3_nxt, en_nxt;
    logic        go_q, go_nxt;

    // Ripple-carry increment of four packed BCD digits (9 wraps to 0).
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Two-flop synchronisers plus one history flop for edge detection.
    // The key idles high so its chain resets to 1 to avoid a false press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_sync_q <= 2'b00;
            start_prev_q <= 1'b0;
            btn_sync_q   <= 2'b11;
            btn_prev_q   <= 1'b1;
        end else begin
            start_sync_q <= {start_sync_q[0], bus.start};
            start_prev_q <= start_sync_q[1];
            btn_sync_q   <= {btn_sync_q[0], bus.btn_n};
            btn_prev_q   <= btn_sync_q[1];
        end
    end

    assign start_s    = start_sync_q[1];
    assign start_rise = start_sync_q[1] & ~start_prev_q;
    assign press      = btn_prev_q & ~btn_sync_q[1];

    // Free-running Fibonacci LFSR, x^12+x^6+x^4+x+1; a non-zero seed keeps it non-zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[10:0], lfsr_q[11] ^ lfsr_q[5] ^ lfsr_q[3] ^ lfsr_q[0]};
        end
    end

    // Next-state, timer and BCD counter decisions.
    always_comb begin
        state_nxt = state_q;
        cd_nxt    = cd_q;
        ms_nxt    = ms_q;
        wait_nxt  = wait_q;
        bcd_nxt   = bcd_q;
        if (!start_s) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_rise) begin
                        state_nxt = ST_CNTDN;
                        cd_nxt    = 4'(COUNT_SEC);
                        ms_nxt    = '0;
                    end
                end
                ST_CNTDN: begin
                    if (press) begin
                        state_nxt = ST_DISQ;
                    end else if (bus.ms_tick) begin
                        if (ms_q == 10'd999) begin
                            ms_nxt = '0;
                            cd_nxt = cd_q - 4'd1;
                            if (cd_q == 4'd1) begin
                                state_nxt = ST_WAIT;
                                wait_nxt  = 13'(WAIT_MIN_MS) + {2'b00, lfsr_q[10:0]};
                            end
                        end else begin
                            ms_nxt = ms_q + 10'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (press) begin
                        state_nxt = ST_DISQ;
                    end else if (bus.ms_tick) begin
                        wait_nxt = wait_q - 13'd1;
                        // A zero load is treated like one so the hold-off can never wrap.
                        if (wait_q <= 13'd1) begin
                            state_nxt = ST_GO;
                            bcd_nxt   = '0;
                        end
                    end
                end
                ST_GO: begin
                    // A press wins over a coincident tick, freezing the pre-tick value.
                    if (press) begin
                        state_nxt = ST_DONE;
                    end else if (bus.ms_tick) begin
                        if (bcd_q == 16'h9999) begin
                            state_nxt = ST_DONE;
                        end else begin
                            bcd_nxt = bcd_inc(bcd_q);
                        end
                    end
                end
                ST_DONE, ST_DISQ: begin
                    state_nxt = state_q;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Display and LED values derived from the upcoming state so they register with it.
    always_comb begin
        d0_nxt = 4'd0;
        d1_nxt = 4'd0;
        d2_nxt = 4'd0;
        d3_nxt = 4'd0;
        en_nxt = 4'b0000;
        go_nxt = 1'b0;
        case (state_nxt)
            ST_CNTDN: begin
                d0_nxt = cd_nxt;
                en_nxt = 4'b0001;
            end
            ST_GO: begin
                {d3_nxt, d2_nxt, d1_nxt, d0_nxt} = bcd_nxt;
                en_nxt = 4'b1111;
                go_nxt = 1'b1;
            end
            ST_DONE: begin
                {d3_nxt, d2_nxt, d1_nxt, d0_nxt} = bcd_nxt;
                en_nxt = 4'b1111;
            end
            ST_DISQ: begin
                d3_nxt = GLYPH_D;
                d2_nxt = GLYPH_I;
                d1_nxt = GLYPH_S;
                en_nxt = 4'b1110;
            end
            default: begin
                en_nxt = 4'b0000;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cd_q    <= '0;
            ms_q    <= '0;
            wait_q  <= '0;
            bcd_q   <= '0;
            d0_q    <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            d3_q    <= '0;
            en_q    <= '0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cd_q    <= cd_nxt;
            ms_q    <= ms_nxt;
            wait_q  <= wait_nxt;
            bcd_q   <= bcd_nxt;
            d0_q    <= d0_nxt;
            d1_q    <= d1_nxt;
            d2_q    <= d2_nxt;
            d3_q    <= d3_nxt;
            en_q    <= en_nxt;
            go_q    <= go_nxt;
        end
    end

    assign bus.digit0   = d0_q;
    assign bus.digit1   = d1_q;
    assign bus.digit2   = d2_q;
    assign bus.digit3   = d3_q;
    assign bus.digit_en = en_q;
    assign bus.go_led   = go_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Bench for reaction_game_ctrl: scenario tasks with randomized timing,
// expectations from a game-level model (tick counts -> decimal digits,
// LFSR stepped from the seed by elapsed clocks -> hold-off length).
module tb_reaction_game_ctrl;

    localparam int          COUNT_SEC   = 3;
    localparam int          WAIT_MIN_MS = 200;
    localparam logic [11:0] LFSR_SEED   = 12'hACE;
    localparam logic [3:0]  GLYPH_D     = 4'd13;
    localparam logic [3:0]  GLYPH_I     = 4'd1;
    localparam logic [3:0]  GLYPH_S     = 4'd5;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CNTDN = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_GO    = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_DISQ  = 3'd5;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   clk_cnt = 0;
    int   last_tick_cnt = 0;

    reaction_game_ctrl_if bus ();

    reaction_game_ctrl #(
        .COUNT_SEC  (COUNT_SEC),
        .WAIT_MIN_MS(WAIT_MIN_MS),
        .LFSR_SEED  (LFSR_SEED),
        .GLYPH_D    (GLYPH_D),
        .GLYPH_I    (GLYPH_I),
        .GLYPH_S    (GLYPH_S)
    ) dut (
        .clk    (clk),
        .reset_n(rst_n),
        .bus    (bus)
    );

    always #10 clk = ~clk;

    // Clocks since reset release; the DUT LFSR has stepped exactly this many times.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) clk_cnt <= 0;
        else        clk_cnt <= clk_cnt + 1;
    end

    function automatic logic [11:0] lfsr_at(input int n);
        logic [11:0] v;
        v = LFSR_SEED;
        for (int i = 0; i < n; i++) v = {v[10:0], v[11] ^ v[5] ^ v[3] ^ v[0]};
        return v;
    endfunction

    function automatic int hold_off(input int tick_clk);
        logic [11:0] v;
        v = lfsr_at(tick_clk);
        return WAIT_MIN_MS + int'(v[10:0]);
    endfunction

    function automatic logic [15:0] bcd_of(input int n);
        int s;
        s = (n > 9999) ? 9999 : n;
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic logic [23:0] snap();
        return {bus.state, bus.go_led, bus.digit_en, bus.digit3, bus.digit2, bus.digit1, bus.digit0};
    endfunction

    // One clock: drive ms_tick for the next posedge, return at the following negedge.
    task automatic cyc(input bit tick);
        bus.ms_tick = tick;
        if (tick) last_tick_cnt = clk_cnt;
        @(negedge clk);
    endtask

    task automatic ticks(input int n, input int period);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1);
            for (int j = 1; j < period; j++) cyc(1'b0);
        end
        bus.ms_tick = 1'b0;
    endtask

    task automatic press_btn(input bit with_tick);
        bus.btn_n = 1'b0;
        cyc(1'b0);
        cyc(1'b0);
        cyc(with_tick);
        bus.ms_tick = 1'b0;
    endtask

    task automatic release_btn();
        bus.btn_n = 1'b1;
        repeat (3) cyc(1'b0);
    endtask

    task automatic start_game();
        int idle;
        idle = $urandom_range(0, 15);
        repeat (idle) cyc(1'b0);
        bus.start = 1'b1;
        repeat (3) cyc(1'b0);
        checks++;
        if (snap() !== {ST_CNTDN, 1'b0, 4'b0001, 12'h000, 4'(COUNT_SEC)}) begin
            errors++;
            $display("FAIL start_game: got %h want %h", snap(), {ST_CNTDN, 1'b0, 4'b0001, 12'h000, 4'(COUNT_SEC)});
        end
    endtask

    task automatic abort(input string where);
        bus.start = 1'b0;
        repeat (3) cyc(1'b0);
        checks++;
        if (snap() !== 24'h0) begin
            errors++;
            $display("FAIL abort_%s: got %h want %h", where, snap(), 24'h0);
        end
    endtask

    task automatic countdown_fast();
        ticks(COUNT_SEC * 1000, 1);
        checks++;
        if ({bus.state, bus.go_led, bus.digit_en} !== {ST_WAIT, 1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL enter_wait: got %h want %h", {bus.state, bus.go_led, bus.digit_en}, {ST_WAIT, 1'b0, 4'b0000});
        end
    endtask

    task automatic wait_for_go();
        int exp_n;
        int n;
        exp_n = hold_off(last_tick_cnt);
        n = 0;
        while (bus.go_led !== 1'b1 && n < exp_n + 5) begin
            ticks(1, 1);
            n++;
        end
        checks++;
        if (n != exp_n) begin
            errors++;
            $display("FAIL hold_off_len: got %0d ticks want %0d", n, exp_n);
        end
        checks++;
        if (snap() !== {ST_GO, 1'b1, 4'hF, 16'h0000}) begin
            errors++;
            $display("FAIL go_entry: got %h want %h", snap(), {ST_GO, 1'b1, 4'hF, 16'h0000});
        end
    endtask

    task automatic to_go();
        start_game();
        countdown_fast();
        wait_for_go();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.btn_n = 1'b1;
        bus.ms_tick = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (snap() !== 24'h0) begin
            errors++;
            $display("FAIL reset: got %h want %h", snap(), 24'h0);
        end
        rst_n = 1'b1;
        repeat (5) cyc(1'b0);
        bus.btn_n = 1'b0;
        repeat (3) cyc(1'b0);
        release_btn();
        ticks(5, 1);
        checks++;
        if (snap() !== 24'h0) begin
            errors++;
            $display("FAIL idle_ignores_press: got %h want %h", snap(), 24'h0);
        end
    endtask

    task automatic test_countdown();
        start_game();
        for (int s = 0; s < COUNT_SEC; s++) begin
            ticks(999, 10);
            checks++;
            if ({bus.state, bus.digit_en, bus.digit0} !== {ST_CNTDN, 4'b0001, 4'(COUNT_SEC - s)}) begin
                errors++;
                $display("FAIL cd_hold_%0d: got %h want %h", s, {bus.state, bus.digit_en, bus.digit0},
                         {ST_CNTDN, 4'b0001, 4'(COUNT_SEC - s)});
            end
            ticks(1, 10);
            if (s < COUNT_SEC - 1) begin
                checks++;
                if ({bus.state, bus.digit0} !== {ST_CNTDN, 4'(COUNT_SEC - s - 1)}) begin
                    errors++;
                    $display("FAIL cd_step_%0d: got %h want %h", s, {bus.state, bus.digit0}, {ST_CNTDN, 4'(COUNT_SEC - s - 1)});
                end
            end else begin
                checks++;
                if ({bus.state, bus.go_led, bus.digit_en} !== {ST_WAIT, 1'b0, 4'b0000}) begin
                    errors++;
                    $display("FAIL cd_to_wait: got %h want %h", {bus.state, bus.go_led, bus.digit_en}, {ST_WAIT, 1'b0, 4'b0000});
                end
            end
        end
        wait_for_go();
    endtask

    task automatic test_go_press();
        ticks(237, 1);
        checks++;
        if (snap() !== {ST_GO, 1'b1, 4'hF, bcd_of(237)}) begin
            errors++;
            $display("FAIL go_live_237: got %h want %h", snap(), {ST_GO, 1'b1, 4'hF, bcd_of(237)});
        end
        press_btn(1'b0);
        checks++;
        if (snap() !== {ST_DONE, 1'b0, 4'hF, bcd_of(237)}) begin
            errors++;
            $display("FAIL go_press_237: got %h want %h", snap(), {ST_DONE, 1'b0, 4'hF, bcd_of(237)});
        end
        release_btn();
        press_btn(1'b0);
        ticks(50, 1);
        release_btn();
        checks++;
        if (snap() !== {ST_DONE, 1'b0, 4'hF, bcd_of(237)}) begin
            errors++;
            $display("FAIL done_frozen: got %h want %h", snap(), {ST_DONE, 1'b0, 4'hF, bcd_of(237)});
        end
        abort("done");
    endtask

    task automatic test_disq_cntdn();
        int r;
        start_game();
        ticks(1000, 1);
        checks++;
        if ({bus.state, bus.digit0} !== {ST_CNTDN, 4'(COUNT_SEC - 1)}) begin
            errors++;
            $display("FAIL disq_cd_value: got %h want %h", {bus.state, bus.digit0}, {ST_CNTDN, 4'(COUNT_SEC - 1)});
        end
        r = $urandom_range(0, 900);
        ticks(r, 1);
        press_btn(1'b0);
        checks++;
        if (snap() !== {ST_DISQ, 1'b0, 4'b1110, GLYPH_D, GLYPH_I, GLYPH_S, 4'h0}) begin
            errors++;
            $display("FAIL disq_cntdn: got %h want %h", snap(), {ST_DISQ, 1'b0, 4'b1110, GLYPH_D, GLYPH_I, GLYPH_S, 4'h0});
        end
        release_btn();
        press_btn(1'b0);
        ticks(20, 1);
        release_btn();
        checks++;
        if (snap() !== {ST_DISQ, 1'b0, 4'b1110, GLYPH_D, GLYPH_I, GLYPH_S, 4'h0}) begin
            errors++;
            $display("FAIL disq_sticky: got %h want %h", snap(), {ST_DISQ, 1'b0, 4'b1110, GLYPH_D, GLYPH_I, GLYPH_S, 4'h0});
        end
        abort("disq");
    endtask

    task automatic test_disq_wait();
        int exp_n;
        int r;
        start_game();
        countdown_fast();
        exp_n = hold_off(last_tick_cnt);
        r = $urandom_range(1, exp_n - 1);
        ticks(r, 1);
        checks++;
        if ({bus.state, bus.go_led} !== {ST_WAIT, 1'b0}) begin
            errors++;
            $display("FAIL still_wait: got %h want %h", {bus.state, bus.go_led}, {ST_WAIT, 1'b0});
        end
        press_btn(1'b0);
        checks++;
        if (snap() !== {ST_DISQ, 1'b0, 4'b1110, GLYPH_D, GLYPH_I, GLYPH_S, 4'h0}) begin
            errors++;
            $display("FAIL disq_wait: got %h want %h", snap(), {ST_DISQ, 1'b0, 4'b1110, GLYPH_D, GLYPH_I, GLYPH_S, 4'h0});
        end
        release_btn();
        abort("disq_wait");
    endtask

    task automatic test_saturate();
        to_go();
        ticks(9999, 1);
        checks++;
        if (snap() !== {ST_GO, 1'b1, 4'hF, bcd_of(9999)}) begin
            errors++;
            $display("FAIL go_9999: got %h want %h", snap(), {ST_GO, 1'b1, 4'hF, bcd_of(9999)});
        end
        ticks(1, 1);
        checks++;
        if (snap() !== {ST_DONE, 1'b0, 4'hF, bcd_of(10000)}) begin
            errors++;
            $display("FAIL timeout_done: got %h want %h", snap(), {ST_DONE, 1'b0, 4'hF, bcd_of(10000)});
        end
        ticks(5, 1);
        checks++;
        if (snap() !== {ST_DONE, 1'b0, 4'hF, bcd_of(9999)}) begin
            errors++;
            $display("FAIL timeout_hold: got %h want %h", snap(), {ST_DONE, 1'b0, 4'hF, bcd_of(9999)});
        end
        abort("timeout");
    endtask

    task automatic test_press_with_tick();
        to_go();
        ticks(41, 1);
        press_btn(1'b1);
        checks++;
        if (snap() !== {ST_DONE, 1'b0, 4'hF, bcd_of(41)}) begin
            errors++;
            $display("FAIL press_with_tick: got %h want %h", snap(), {ST_DONE, 1'b0, 4'hF, bcd_of(41)});
        end
        ticks(3, 1);
        release_btn();
        abort("press_tick");
    endtask

    task automatic test_abort_states();
        int r;
        start_game();
        r = $urandom_range(1, 2500);
        ticks(r, 1);
        abort("cntdn");
        start_game();
        countdown_fast();
        r = $urandom_range(1, WAIT_MIN_MS - 1);
        ticks(r, 1);
        abort("wait");
    endtask

    task automatic test_glitch_hold();
        int r;
        bus.btn_n = 1'b0;
        repeat (4) cyc(1'b0);
        to_go();
        r = $urandom_range(1, 300);
        ticks(r, 1);
        #2 bus.btn_n = 1'b1;
        #3 bus.btn_n = 1'b0;
        repeat (4) cyc(1'b0);
        checks++;
        if (snap() !== {ST_GO, 1'b1, 4'hF, bcd_of(r)} || $isunknown(snap())) begin
            errors++;
            $display("FAIL glitch_high: got %h want %h", snap(), {ST_GO, 1'b1, 4'hF, bcd_of(r)});
        end
        release_btn();
        #2 bus.btn_n = 1'b0;
        #3 bus.btn_n = 1'b1;
        repeat (4) cyc(1'b0);
        checks++;
        if (snap() !== {ST_GO, 1'b1, 4'hF, bcd_of(r)} || $isunknown(snap())) begin
            errors++;
            $display("FAIL glitch_low: got %h want %h", snap(), {ST_GO, 1'b1, 4'hF, bcd_of(r)});
        end
        abort("go");
    endtask

    task automatic test_reset_mid_go();
        int r;
        to_go();
        r = $urandom_range(1, 300);
        ticks(r, 1);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (snap() !== 24'h0) begin
            errors++;
            $display("FAIL reset_async: got %h want %h", snap(), 24'h0);
        end
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cyc(1'b0);
        checks++;
        if (snap() !== 24'h0) begin
            errors++;
            $display("FAIL reset_release: got %h want %h", snap(), 24'h0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.btn_n = 1'b1;
        bus.ms_tick = 1'b0;
        test_reset();
        test_countdown();
        test_go_press();
        test_disq_cntdn();
        test_disq_wait();
        test_saturate();
        test_press_with_tick();
        test_abort_states();
        test_glitch_hold();
        test_reset_mid_go();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #(98000 * 20);
        errors++;
        $display("FAIL watchdog: run exceeded %0d clocks", 98000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
